// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch-address controller.
//   DEF_RESET_VECTOR : default PC loaded on reset
//   DEF_HALT_ADDR    : default fetch address that terminates execution
//   pc_state_t       : sequencer state (RUN, SLOT = delay slot, HALT)
package mips_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SLOT = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/mips_pc_sequencer.sv
// Fetch-address controller for the single-cycle Harvard MIPS core.
// Owns the PC, sequences branch/jump redirects through the architectural
// delay slot and detects program termination (fetch from HALT_ADDR).
// Ports:
//   clk, reset (async, active-low), clk_enable (global freeze), stall (hold)
//   branch_taken/branch_target : conditional branch resolved true + target
//   jump_valid/jump_target     : J/JAL/JR/JALR + resolved target (wins over branch)
//   instr_address : current fetch PC
//   active        : 1 until the core halts
//   in_delay_slot : current instruction sits in a delay slot
//   link_address  : instr_address + 8 for link writeback
//   fault         : sticky misaligned-target / redirect-in-slot flag
module mips_pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_valid,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_address,
  output logic        active,
  output logic        in_delay_slot,
  output logic [31:0] link_address,
  output logic        fault
);

  pc_state_t   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pending;
  logic        r_fault;

  pc_state_t   w_next_state;
  logic [31:0] w_next_pc;
  logic [31:0] w_next_pending;
  logic        w_next_fault;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_update;

  assign w_update   = clk_enable & ~stall;
  assign w_redirect = jump_valid | branch_taken;
  // A jump and a taken branch in the same cycle: the jump wins.
  assign w_target   = jump_valid ? jump_target : branch_target;

  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_pending = r_pending;
    w_next_fault   = r_fault;
    unique case (r_state)
      RUN: begin
        if (w_redirect && (w_target[1:0] != 2'b00)) begin
          // Misaligned redirect: abort without executing the delay slot.
          w_next_fault = 1'b1;
          w_next_state = HALT;
          w_next_pc    = HALT_ADDR;
        end else begin
          w_next_pc = r_pc + 32'd4;
          if (w_redirect) begin
            w_next_pending = w_target;
            w_next_state   = SLOT;
          end
        end
      end
      SLOT: begin
        // A redirect from the slot instruction is illegal: flag it, but the
        // already-captured target is still taken.
        w_next_pc    = r_pending;
        w_next_state = RUN;
        if (w_redirect) w_next_fault = 1'b1;
      end
      default: begin
        w_next_state = HALT;
        w_next_pc    = HALT_ADDR;
      end
    endcase
    // Reaching HALT_ADDR by any path (including PC+4 wrap) halts in the same update.
    if ((r_state != HALT) && (w_next_pc == HALT_ADDR)) begin
      w_next_state = HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_pc      <= RESET_VECTOR;
      r_pending <= 32'd0;
      r_fault   <= 1'b0;
    end else if (w_update) begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_pending <= w_next_pending;
      r_fault   <= w_next_fault;
    end
  end

  assign instr_address = r_pc;
  assign link_address  = r_pc + 32'd8;
  assign active        = (r_state != HALT);
  assign in_delay_slot = (r_state == SLOT);
  assign fault         = r_fault;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed bench for the MIPS fetch-address controller. Each step drives the
// redirect/enable inputs, queues the expected post-update outputs, and pops
// and compares them one time unit after the rising edge.
module tb_mips_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic [31:0] instr_address;
  logic        active;
  logic        in_delay_slot;
  logic [31:0] link_address;
  logic        fault;

  typedef struct {
    logic [31:0] pc;
    logic        act;
    logic        slot;
    logic        flt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mips_pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .instr_address (instr_address),
    .active        (active),
    .in_delay_slot (in_delay_slot),
    .link_address  (link_address),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog expired");
  end

  task automatic expect_push(input logic [31:0] pc, input logic act, input logic slot,
                             input logic flt, input string tag);
    exp_t e;
    e.pc = pc; e.act = act; e.slot = slot; e.flt = flt; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    logic [31:0] exp_link;
    if (q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL scoreboard_empty: observed pc %h, required a queued expectation", instr_address);
    end else begin
      e = q.pop_front();
      exp_link = e.pc + 32'd8;
      n_cmp++;
      assert (instr_address === e.pc) else begin
        n_err++; $error("FAIL %s.pc: observed %h expected %h", e.tag, instr_address, e.pc);
      end
      n_cmp++;
      assert (link_address === exp_link) else begin
        n_err++; $error("FAIL %s.link: observed %h expected %h", e.tag, link_address, exp_link);
      end
      n_cmp++;
      assert (active === e.act) else begin
        n_err++; $error("FAIL %s.active: observed %b expected %b", e.tag, active, e.act);
      end
      n_cmp++;
      assert (in_delay_slot === e.slot) else begin
        n_err++; $error("FAIL %s.slot: observed %b expected %b", e.tag, in_delay_slot, e.slot);
      end
      n_cmp++;
      assert (fault === e.flt) else begin
        n_err++; $error("FAIL %s.fault: observed %b expected %b", e.tag, fault, e.flt);
      end
    end
  endtask

  // One clock update with the given inputs, then check the outputs.
  task automatic step(input logic ce, input logic st, input logic jv, input logic [31:0] jt,
                      input logic bt, input logic [31:0] btt,
                      input logic [31:0] epc, input logic eact, input logic eslot,
                      input logic eflt, input string tag);
    clk_enable = ce; stall = st;
    jump_valid = jv; jump_target = jt;
    branch_taken = bt; branch_target = btt;
    expect_push(epc, eact, eslot, eflt, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic nop(input logic [31:0] epc, input logic eslot, input logic eflt, input string tag);
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, epc, 1'b1, eslot, eflt, tag);
  endtask

  // Asserted mid-cycle: outputs must change without waiting for an edge.
  task automatic async_reset(input string tag);
    jump_valid = 1'b0; branch_taken = 1'b0; clk_enable = 1'b1; stall = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    expect_push(32'hBFC0_0000, 1'b1, 1'b0, 1'b0, tag);
    check_pop();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; clk_enable = 1'b1; stall = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0;
    jump_valid = 1'b0; jump_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    expect_push(32'hBFC0_0000, 1'b1, 1'b0, 1'b0, "reset_state");
    check_pop();
    reset = 1'b1;

    // 1: sequential fetch
    nop(32'hBFC0_0004, 1'b0, 1'b0, "seq1");
    nop(32'hBFC0_0008, 1'b0, 1'b0, "seq2");

    // 2: taken branch through the delay slot
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0018, 32'hBFC0_000C, 1'b1, 1'b1, 1'b0, "br_slot");
    nop(32'hBFC0_0018, 1'b0, 1'b0, "br_target");

    // 3: jump to the halt address
    nop(32'hBFC0_001C, 1'b0, 1'b0, "run1c");
    nop(32'hBFC0_0020, 1'b0, 1'b0, "run20");
    nop(32'hBFC0_0024, 1'b0, 1'b0, "run24");
    nop(32'hBFC0_0028, 1'b0, 1'b0, "run28");
    nop(32'hBFC0_002C, 1'b0, 1'b0, "run2c");
    step(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'd0, 32'hBFC0_0030, 1'b1, 1'b1, 1'b0, "jhalt_slot");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, "jhalt_pc");
    for (int i = 0; i < 20; i++) begin
      logic [1:0] sel;
      sel = 2'(i);
      step(1'b1, 1'b0, sel[0], $urandom, sel[1], $urandom, 32'h0, 1'b0, 1'b0, 1'b0, "halted");
    end

    // 4: jump and branch together, jump wins
    async_reset("reset_from_halt");
    step(1'b1, 1'b0, 1'b1, 32'hBFC0_0100, 1'b1, 32'hBFC0_0200, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0, "jb_slot");
    nop(32'hBFC0_0100, 1'b0, 1'b0, "jb_target");

    // 5: redirect inside the slot, then misaligned target
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0140, 32'hBFC0_0104, 1'b1, 1'b1, 1'b0, "br2_slot");
    step(1'b1, 1'b0, 1'b1, 32'hBFC0_0300, 1'b0, 32'd0, 32'hBFC0_0140, 1'b1, 1'b0, 1'b1, "slot_redirect");
    nop(32'hBFC0_0144, 1'b0, 1'b1, "fault_runs_on");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0102, 32'h0, 1'b0, 1'b0, 1'b1, "misaligned");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b1, "misaligned_hold");

    // 6: freeze mid-slot, then async reset mid-slot
    async_reset("reset_clears_fault");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0080, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0, "br3_slot");
    step(1'b1, 1'b1, 1'b1, 32'hBFC0_0500, 1'b0, 32'd0, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0, "stall_hold");
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_0600, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0, "ce_hold");
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'hBFC0_0004, 1'b1, 1'b1, 1'b0, "both_hold");
    nop(32'hBFC0_0080, 1'b0, 1'b0, "br3_target");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'hBFC0_00C0, 32'hBFC0_0084, 1'b1, 1'b1, 1'b0, "br4_slot");
    async_reset("reset_mid_slot");
    nop(32'hBFC0_0004, 1'b0, 1'b0, "pending_dropped");

    // PC+4 wrap into the halt address
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'd0, 32'hBFC0_0008, 1'b1, 1'b1, 1'b0, "jwrap_slot");
    nop(32'hFFFF_FFF8, 1'b0, 1'b0, "wrap_f8");
    nop(32'hFFFF_FFFC, 1'b0, 1'b0, "wrap_fc");
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, "wrap_halt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
